// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the MIPS run-and-dump debug controller.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DUMP_REG,
        ST_DUMP_MEM,
        ST_DONE
    } ctrl_state_t;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
        return word_idx << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/dump_out_slot.sv
// One-entry valid/ready output register: loads into a free slot, holds under
// backpressure, and empties when told there is nothing left to send.
module dump_out_slot
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              load_kind,
    input  logic [IDX_W-1:0]  load_index,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_kind,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              slot_free
);

    assign slot_free = !out_valid || out_ready;

    // A held beat is never overwritten, even if load is raised while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_kind  <= KIND_REG;
            out_index <= '0;
            out_data  <= '0;
        end else if (slot_free) begin
            if (load) begin
                out_valid <= 1'b1;
                out_kind  <= load_kind;
                out_index <= load_index;
                out_data  <= load_data;
            end else if (clear) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_dump_ctrl.sv
// Run-and-dump controller: steps the CPU for a bounded number of cycles or until
// halt, then streams the register file followed by data memory over valid/ready.
module cpu_run_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_CYCLES = 32,
    parameter int CNT_W      = 16,
    parameter int REG_COUNT  = 32,
    parameter int MEM_WORDS  = 64,
    parameter int IDX_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpu_halt,
    output logic              cpu_en,
    output logic [4:0]        dbg_reg_a,
    input  logic [DATA_W-1:0] dbg_reg_rd,
    output logic [31:0]       dbg_mem_a,
    input  logic [DATA_W-1:0] dbg_mem_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_kind,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycles_run
);

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_REG   = IDX_W'(REG_COUNT - 1);
    localparam logic [IDX_W-1:0] LAST_MEM   = IDX_W'(MEM_WORDS - 1);
    localparam logic [IDX_W-1:0] MEM_END    = IDX_W'(MEM_WORDS);

    ctrl_state_t       state;
    ctrl_state_t       next_state;
    logic [IDX_W-1:0]  index;
    logic              slot_free;
    logic              slot_load;
    logic              slot_clear;
    logic              load_kind;
    logic [DATA_W-1:0] load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The register-to-memory handoff happens in the cycle that loads the last
    // register, so the memory stream follows without a bubble.
    always_comb begin
        next_state = state;
        slot_load  = 1'b0;
        slot_clear = 1'b0;
        load_kind  = KIND_REG;
        load_data  = dbg_reg_rd;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_halt || (cycles_run == LAST_CYCLE)) begin
                    next_state = ST_DUMP_REG;
                end
            end
            ST_DUMP_REG: begin
                if (slot_free) begin
                    slot_load = 1'b1;
                    if (index == LAST_REG) begin
                        next_state = ST_DUMP_MEM;
                    end
                end
            end
            ST_DUMP_MEM: begin
                load_kind = KIND_MEM;
                load_data = dbg_mem_rd;
                if (slot_free) begin
                    if (index != MEM_END) begin
                        slot_load = 1'b1;
                    end else begin
                        slot_clear = 1'b1;
                    end
                end
                if (out_valid && out_ready && (out_kind == KIND_MEM) && (out_index == LAST_MEM)) begin
                    next_state = ST_DONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // cpu_en is registered from next_state so it is high in exactly the RUN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_en     <= 1'b0;
            cycles_run <= '0;
            index      <= '0;
        end else begin
            cpu_en <= (next_state == ST_RUN);
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cycles_run <= '0;
                        index      <= '0;
                    end
                end
                ST_RUN: begin
                    cycles_run <= cycles_run + 1'b1;
                end
                ST_DUMP_REG: begin
                    if (slot_load) begin
                        index <= (index == LAST_REG) ? '0 : index + 1'b1;
                    end
                end
                ST_DUMP_MEM: begin
                    if (slot_load) begin
                        index <= index + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_reg_a = index[4:0];
    assign dbg_mem_a = word_to_byte_addr(32'(index));

    assign busy = (state == ST_RUN) || (state == ST_DUMP_REG) || (state == ST_DUMP_MEM);
    assign done = (state == ST_DONE);

    dump_out_slot #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (slot_load),
        .clear      (slot_clear),
        .load_kind  (load_kind),
        .load_index (index),
        .load_data  (load_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_kind   (out_kind),
        .out_index  (out_index),
        .out_data   (out_data),
        .slot_free  (slot_free)
    );

endmodule

// File: tb/tb_cpu_run_dump_ctrl.sv
// Directed bench for cpu_run_dump_ctrl with a preloaded register-file and
// data-memory model behind the debug read ports.
module tb_cpu_run_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cpu_halt;
    logic        cpu_en;
    logic [4:0]  dbg_reg_a;
    logic [31:0] dbg_reg_rd;
    logic [31:0] dbg_mem_a;
    logic [31:0] dbg_mem_rd;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [15:0] out_index;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [15:0] cycles_run;

    logic [31:0] reg_file [32];
    logic [31:0] ram [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dbg_reg_rd = reg_file[dbg_reg_a];
    assign dbg_mem_rd = ((dbg_mem_a[1:0] == 2'b00) && (dbg_mem_a[31:2] < 30'd64))
                        ? ram[dbg_mem_a[7:2]] : 32'hDEADBEEF;

    cpu_run_dump_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cpu_halt   (cpu_halt),
        .cpu_en     (cpu_en),
        .dbg_reg_a  (dbg_reg_a),
        .dbg_reg_rd (dbg_reg_rd),
        .dbg_mem_a  (dbg_mem_a),
        .dbg_mem_rd (dbg_mem_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_index  (out_index),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .cycles_run (cycles_run)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [48:0] expectedBeat(input int n);
        if (n < 32) begin
            return {1'b0, 16'(n), 32'(n * 3)};
        end
        return {1'b1, 16'(n - 32), 32'(1000 + n - 32)};
    endfunction

    // Returns on the first falling edge inside RUN.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runAndDump(input int halt_at, input int exp_cycles, input bit toggle, input bit start_in_dump);
        int          en_count;
        int          cyc;
        int          exp_n;
        int          gap_cnt;
        int          hold_cnt;
        bit          toggled;
        bit          pulsed;
        logic [48:0] snap;
        logic [48:0] got;
        applyStimulus();
        checkOutput("start_done_low", done, 0);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_cycles_clear", cycles_run, 0);
        en_count = 0;
        cyc = 0;
        while (cpu_en && cyc < 200) begin
            en_count++;
            cpu_halt = (en_count == halt_at);
            @(negedge clk);
            cyc++;
        end
        cpu_halt = 1'b0;
        checkOutput("cpu_en_cycles", en_count, exp_cycles);
        checkOutput("cycles_run", cycles_run, exp_cycles);
        checkOutput("dump_busy", busy, 1);

        exp_n = 0;
        cyc = 0;
        gap_cnt = 0;
        hold_cnt = 0;
        toggled = 1'b0;
        pulsed = 1'b0;
        snap = '0;
        while (exp_n < 96 && cyc < 500) begin
            got = {out_kind, out_index, out_data};
            if (hold_cnt > 0) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_beat", got, snap);
                checkOutput("hold_mem_addr", dbg_mem_a, 0);
                hold_cnt--;
                out_ready = (hold_cnt == 0);
            end else if (toggle && !toggled && out_valid && out_kind == 1'b0 && out_index == 16'd31) begin
                snap = got;
                toggled = 1'b1;
                hold_cnt = 2;
                out_ready = 1'b0;
            end
            start = start_in_dump && (exp_n == 50) && !pulsed;
            if (start) pulsed = 1'b1;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("beat%0d", exp_n), got, expectedBeat(exp_n));
                exp_n++;
            end else if (!out_valid && exp_n > 0) begin
                gap_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        checkOutput("beat_count", exp_n, 96);
        checkOutput("no_gaps", gap_cnt, 0);
        if (toggle) checkOutput("toggle_seen", toggled, 1);
        if (start_in_dump) checkOutput("start_pulsed", pulsed, 1);
        checkOutput("done_after_last", done, 1);
        checkOutput("valid_in_done", out_valid, 0);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("cpu_en_in_done", cpu_en, 0);
        checkOutput("cycles_held", cycles_run, exp_cycles);
    endtask

    initial begin
        int stray;
        for (int i = 0; i < 32; i++) reg_file[i] = 32'(i * 3);
        for (int j = 0; j < 64; j++) ram[j] = 32'(1000 + j);
        rst_n = 1'b0;
        start = 1'b0;
        cpu_halt = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_cpu_en", cpu_en, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_kind", out_kind, 0);
        checkOutput("rst_index", out_index, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_cycles", cycles_run, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mem_addr", dbg_mem_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset in the middle of RUN");
        applyStimulus();
        repeat (9) @(negedge clk);
        checkOutput("midrun_cycles", cycles_run, 9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_cpu_en", cpu_en, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_cycles", cycles_run, 0);
        checkOutput("abort_index", out_index, 0);
        checkOutput("abort_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (out_valid || busy || cpu_en || done) stray++;
        end
        checkOutput("no_activity_after_abort", stray, 0);

        $display("[TB] full run to cycle limit");
        runAndDump(0, 32, 1'b0, 1'b0);
        $display("[TB] halt on 7th cycle, backpressure at boundary, start during dump");
        runAndDump(7, 7, 1'b1, 1'b1);
        $display("[TB] halt coincides with cycle limit");
        runAndDump(32, 32, 1'b0, 1'b0);
        $display("[TB] halt on first cycle");
        runAndDump(1, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
